sdram_req_arbiter: RTL and testbench

Arbitrates the single application request port of the SDRAM controller core between two requesters: the video refresh reader (8-word read bursts) and the host write path from the FTDI/USB side (single-word writes). It replaces the ad-hoc OR/mux and `rd_valid` delay-line glue in the top level with a registered state machine. The state machine guarantees:
- one request in flight at a time;
- no write issued while read data is still returning;
- bounded write starvation under continuous video load.

---
 rtl/sdram_arb_pkg.sv | 30 +++
 rtl/sdram_req_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdram_arb_pkg;

  // Width of the burst length field presented to the controller core.
  localparam int LEN_W = 9;

  // Width of the outstanding-read-word counter.
  localparam int REM_W = 4;

  // Width of the consecutive-read-grant counter used for write starvation control.
  localparam int RUN_W = 3;

  // Arbiter states. The ST_ prefix keeps the literals from colliding with
  // the arbiter's GUARD parameter.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_GUARD   = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_DATA = 3'd5
  } arb_state_e;

  // Increment that sticks at the given limit instead of running past it.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] val,
                                               input logic [RUN_W-1:0] lim);
    return (val >= lim) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/sdram_req_arbiter.sv
// Shares the SDRAM controller's single application request port between the
// video refresh reader (read bursts) and the host write path (single writes).
// Only one request is in flight at a time. Writes wait until all read data has
// returned and a short guard gap has passed. Reads are preferred, but a
// pending write is forced through after MAX_RD_RUN consecutive read grants.
// GUARD must be at least 1.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW         = 25,
  parameter int RD_LEN     = 8,
  parameter int WR_LEN     = 1,
  parameter int GUARD      = 2,
  parameter int MAX_RD_RUN = 4
) (
  input  logic             mem_clk,
  input  logic             reset_n,
  input  logic             init_done,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ack,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  output logic             wr_ack,
  output logic             wr_next,
  output logic             app_req,
  output logic [AW-1:0]    app_req_addr,
  output logic [LEN_W-1:0] app_req_len,
  output logic             app_req_wr_n,
  output logic             app_req_dma_last,
  input  logic             app_req_ack,
  input  logic             app_rd_valid,
  input  logic             app_wr_next_req,
  input  logic             app_last_wr,
  output logic             busy,
  output logic             rd_ovf_err
);

  localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GCW-1:0]   GUARD_LAST = GCW'(GUARD - 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_RD_RUN);
  localparam logic [REM_W-1:0] RD_WORDS   = REM_W'(RD_LEN);

  arb_state_e       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wr_n_q, wr_n_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [GCW-1:0]   guard_cnt_q, guard_cnt_d;
  logic             ovf_q, ovf_d;

  logic in_idle;
  logic write_wins;
  logic grant_rd;
  logic grant_wr;

  // Grant decision: reads win unless nothing is reading or the write has waited long enough.
  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    write_wins = !rd_req || (wr_req && (run_cnt_q == RUN_MAX));
    grant_rd   = in_idle && init_done && rd_req && !write_wins;
    grant_wr   = in_idle && init_done && wr_req && write_wins;
  end

  // Next-state logic: request register capture, burst tracking and guard timing.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_n_d      = wr_n_q;
    rem_d       = rem_q;
    guard_cnt_d = guard_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d = ST_RD_REQ;
          addr_d  = rd_addr;
          len_d   = LEN_W'(RD_LEN);
          wr_n_d  = 1'b1;
        end else if (grant_wr) begin
          state_d = ST_WR_REQ;
          addr_d  = wr_addr;
          len_d   = LEN_W'(WR_LEN);
          wr_n_d  = 1'b0;
        end
      end

      ST_RD_REQ: begin
        if (app_req_ack) begin
          state_d = ST_RD_DATA;
          rem_d   = RD_WORDS;
        end
      end

      ST_RD_DATA: begin
        if (app_rd_valid && (rem_q != '0)) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) begin
            state_d     = ST_GUARD;
            guard_cnt_d = '0;
          end
        end
      end

      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d     = ST_IDLE;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end

      ST_WR_REQ: begin
        if (app_req_ack) begin
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (app_last_wr) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts read grants that bypassed a waiting write.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (grant_wr) begin
      run_cnt_d = '0;
    end else if (grant_rd && wr_req) begin
      run_cnt_d = sat_inc(run_cnt_q, RUN_MAX);
    end else if (in_idle && !wr_req) begin
      run_cnt_d = '0;
    end
  end

  // Overrun detect: read data the arbiter is not expecting latches the error flag.
  always_comb begin
    ovf_d = ovf_q;
    if (app_rd_valid && ((state_q != ST_RD_DATA) || (rem_q == '0))) begin
      ovf_d = 1'b1;
    end
  end

  // State and datapath registers; the request defaults to a read direction out of reset.
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_n_q      <= 1'b1;
      rem_q       <= '0;
      run_cnt_q   <= '0;
      guard_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_n_q      <= wr_n_d;
      rem_q       <= rem_d;
      run_cnt_q   <= run_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Output decode: request strobes follow the registered state, acks follow the core.
  always_comb begin
    app_req          = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    app_req_addr     = addr_q;
    app_req_len      = len_q;
    app_req_wr_n     = wr_n_q;
    app_req_dma_last = app_req && wr_n_q;
    rd_ack           = app_req_ack && (state_q == ST_RD_REQ);
    wr_ack           = app_req_ack && (state_q == ST_WR_REQ);
    wr_next          = app_wr_next_req && (state_q == ST_WR_DATA);
    busy             = (state_q != ST_IDLE);
    rd_ovf_err       = ovf_q;
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: a cycle-by-cycle vector table for a
// read followed by a write, then directed sequences for the multi-cycle cases.
module tb_sdram_req_arbiter;

  localparam int AW      = 25;
  localparam int GUARD_N = 2;
  localparam int MAXW    = 60;

  logic          mem_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          init_done = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_ack;
  logic          wr_next;
  logic          app_req;
  logic [AW-1:0] app_req_addr;
  logic [8:0]    app_req_len;
  logic          app_req_wr_n;
  logic          app_req_dma_last;
  logic          app_req_ack = 1'b0;
  logic          app_rd_valid = 1'b0;
  logic          app_wr_next_req = 1'b0;
  logic          app_last_wr = 1'b0;
  logic          busy;
  logic          rd_ovf_err;

  int checks = 0;
  int errors = 0;

  sdram_req_arbiter #(
    .AW(AW), .RD_LEN(8), .WR_LEN(1), .GUARD(GUARD_N), .MAX_RD_RUN(4)
  ) dut (
    .mem_clk(mem_clk), .reset_n(reset_n), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_next(wr_next),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_dma_last(app_req_dma_last),
    .app_req_ack(app_req_ack), .app_rd_valid(app_rd_valid),
    .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .busy(busy), .rd_ovf_err(rd_ovf_err)
  );

  always #5 mem_clk = ~mem_clk;

  // One vector = inputs held for one cycle plus the outputs expected during it.
  // Flag order: {app_req, wr_n, dma_last, rd_ack, wr_ack, wr_next, busy, ovf}.
  typedef struct {
    logic          rd, wr, ack, vld, wnext, lastwr;
    logic [7:0]    expFlags;
    logic [8:0]    expLen;
    logic [AW-1:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic rd, input logic wr, input logic ack,
                                 input logic vld, input logic wnext, input logic lastwr,
                                 input logic [7:0] flags, input logic [8:0] len,
                                 input logic [AW-1:0] addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ack = ack; v.vld = vld; v.wnext = wnext; v.lastwr = lastwr;
    v.expFlags = flags; v.expLen = len; v.expAddr = addr;
    return v;
  endfunction

  function automatic logic [7:0] outFlags();
    return {app_req, app_req_wr_n, app_req_dma_last, rd_ack, wr_ack, wr_next, busy, rd_ovf_err};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge mem_clk);
    @(negedge mem_clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    rd_req = v.rd; wr_req = v.wr; app_req_ack = v.ack;
    app_rd_valid = v.vld; app_wr_next_req = v.wnext; app_last_wr = v.lastwr;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (3) @(negedge mem_clk);
    reset_n = 1'b1;
  endtask

  // Steps until app_req is seen, returning the number of cycles stepped.
  task automatic waitReq(input string name, output int n);
    n = 0;
    while (!app_req && n < MAXW) begin
      stepCycle();
      n++;
    end
    if (!app_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: app_req timeout, got 0, expected 1", name);
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < MAXW) begin
      stepCycle();
      n++;
    end
    checkOutput(name, busy, 0);
  endtask

  task automatic readValids(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      app_rd_valid = 1'b1;
      stepCycle();
    end
    app_rd_valid = 1'b0;
  endtask

  task automatic serveGrant(output logic wrn, output logic [8:0] len);
    int n;
    waitReq("starv_wait", n);
    wrn = app_req_wr_n;
    len = app_req_len;
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    if (wrn) begin
      readValids(8);
    end else begin
      app_wr_next_req = 1'b1;
      app_last_wr = 1'b1;
      stepCycle();
      app_wr_next_req = 1'b0;
      app_last_wr = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic wrn;
    logic [8:0] len;

    rd_addr = 25'h000100;
    wr_addr = 25'h0002AA;
    doReset();
    #1;
    checkOutput("reset_flags", outFlags(), 8'b0100_0000);
    checkOutput("reset_len", app_req_len, 0);
    checkOutput("reset_addr", app_req_addr, 0);
    #1;
    init_done = 1'b1;

    // Single read (ack three cycles after the request, eight valids with a gap),
    // then a write raised during the guard gap.
    vecs.push_back(mkVec(0,0,0,0,0,0, 8'b0100_0000, 0, 0));
    vecs.push_back(mkVec(1,0,0,0,0,0, 8'b0100_0000, 0, 0));
    vecs.push_back(mkVec(1,0,0,0,0,0, 8'b1110_0010, 8, 25'h100));
    vecs.push_back(mkVec(1,0,0,0,0,0, 8'b1110_0010, 8, 25'h100));
    vecs.push_back(mkVec(1,0,1,0,0,0, 8'b1111_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,0,0,0,0,0, 8'b0100_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,0,0,1,0,0, 8'b0100_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,0,0,0,0,0, 8'b0100_0010, 8, 25'h100));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mkVec(0,0,0,1,0,0, 8'b0100_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,1,0,0,0,0, 8'b0100_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,1,0,0,0,0, 8'b0100_0010, 8, 25'h100));
    vecs.push_back(mkVec(0,1,0,0,0,0, 8'b0100_0000, 8, 25'h100));
    vecs.push_back(mkVec(0,1,0,0,0,0, 8'b1000_0010, 1, 25'h2AA));
    vecs.push_back(mkVec(0,1,1,0,0,0, 8'b1000_1010, 1, 25'h2AA));
    vecs.push_back(mkVec(0,0,0,0,1,0, 8'b0000_0110, 1, 25'h2AA));
    vecs.push_back(mkVec(0,0,0,0,1,1, 8'b0000_0110, 1, 25'h2AA));
    vecs.push_back(mkVec(0,0,1,0,1,0, 8'b0000_0000, 1, 25'h2AA));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_flags", i), outFlags(), vecs[i].expFlags);
      checkOutput($sformatf("vec%0d_len", i), app_req_len, vecs[i].expLen);
      checkOutput($sformatf("vec%0d_addr", i), app_req_addr, vecs[i].expAddr);
      stepCycle();
    end
    applyStimulus(mkVec(0,0,0,0,0,0, 0, 0, 0));
    stepCycle();

    // Contention: both requests in the same cycle, read goes first.
    rd_req = 1'b1;
    wr_req = 1'b1;
    stepCycle();
    checkOutput("cont_first_req", app_req, 1);
    checkOutput("cont_first_wrn", app_req_wr_n, 1);
    app_req_ack = 1'b1;
    #1;
    checkOutput("cont_rd_ack", rd_ack, 1);
    checkOutput("cont_no_wr_ack", wr_ack, 0);
    stepCycle();
    app_req_ack = 1'b0;
    rd_req = 1'b0;
    readValids(8);
    waitReq("cont_wr_wait", n);
    checkOutput("cont_wr_gap", n, GUARD_N + 1);
    checkOutput("cont_wr_wrn", app_req_wr_n, 0);
    checkOutput("cont_wr_len", app_req_len, 1);
    app_req_ack = 1'b1;
    #1;
    checkOutput("cont_wr_ack", wr_ack, 1);
    stepCycle();
    app_req_ack = 1'b0;
    app_wr_next_req = 1'b1;
    app_last_wr = 1'b1;
    stepCycle();
    app_wr_next_req = 1'b0;
    app_last_wr = 1'b0;
    // wr_req stayed high: back-to-back write follows after one idle cycle.
    waitReq("b2b_wr_wait", n);
    checkOutput("b2b_wr_gap", n, 1);
    checkOutput("b2b_wr_wrn", app_req_wr_n, 0);
    wr_req = 1'b0;
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    app_last_wr = 1'b1;
    stepCycle();
    app_last_wr = 1'b0;
    waitIdle("cont_idle");
    stepCycle();

    // Starvation: both requests held, every fifth grant must be the write.
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int g = 1; g <= 10; g++) begin
      serveGrant(wrn, len);
      checkOutput($sformatf("starv_grant%0d_wrn", g), wrn, (g % 5 == 0) ? 1'b0 : 1'b1);
      if (g % 5 == 0) checkOutput($sformatf("starv_grant%0d_len", g), len, 1);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    waitIdle("starv_idle");

    // Data overrun: a ninth valid after a completed burst.
    rd_req = 1'b1;
    stepCycle();
    checkOutput("ovf_req", app_req, 1);
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    rd_req = 1'b0;
    readValids(8);
    checkOutput("ovf_clean", rd_ovf_err, 0);
    readValids(1);
    checkOutput("ovf_set", rd_ovf_err, 1);
    repeat (20) stepCycle();
    checkOutput("ovf_sticky", rd_ovf_err, 1);

    // Reset in the middle of RD_DATA clears everything without a clock edge.
    rd_req = 1'b1;
    stepCycle();
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    rd_req = 1'b0;
    readValids(4);
    checkOutput("rst_pre_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_flags", outFlags(), 8'b0100_0000);
    checkOutput("rst_async_len", app_req_len, 0);
    checkOutput("rst_async_addr", app_req_addr, 0);
    stepCycle();
    reset_n = 1'b1;
    rd_addr = 25'h001234;
    rd_req = 1'b1;
    stepCycle();
    checkOutput("rst_regrant_req", app_req, 1);
    checkOutput("rst_regrant_addr", app_req_addr, 25'h001234);
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    rd_req = 1'b0;
    readValids(8);
    waitIdle("rst_idle");

    // init_done low blocks grants; the grant follows one edge after it rises.
    init_done = 1'b0;
    rd_req = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      stepCycle();
      if (app_req || busy) seen = 1'b1;
    end
    checkOutput("init_blocked", seen, 0);
    init_done = 1'b1;
    stepCycle();
    checkOutput("init_grant", app_req, 1);
    app_req_ack = 1'b1;
    stepCycle();
    app_req_ack = 1'b0;
    rd_req = 1'b0;
    readValids(8);
    waitIdle("init_idle");
    checkOutput("final_no_ovf", rd_ovf_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
